// File: rtl/qam16_demapper.sv
// qam16_demapper: hard-decision 16QAM Gray demapper with an adaptive inner/outer threshold
// and an MSB-first serializer that accepts back-to-back symbols without a gap.
module qam16_demapper #(
  parameter int IW       = 27,
  parameter int AVG_LOG2 = 4,
  parameter int THR_INIT = 2000,
  parameter int BIT_DIV  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [IW-1:0] di,
  input  logic signed [IW-1:0] dq,
  input  logic                 din_valid,
  input  logic                 bitsync,
  output logic [3:0]           sym_out,
  output logic                 sym_valid,
  output logic                 bit_out,
  output logic                 bit_valid,
  output logic [IW-1:0]        thr,
  output logic                 thr_valid,
  output logic                 overrun
);
  localparam int AW = IW + AVG_LOG2 + 1;
  localparam int DW = BIT_DIV > 1 ? $clog2(BIT_DIV) : 1;
  localparam logic [IW-1:0] MAXV = {1'b0, {(IW-1){1'b1}}};
  localparam logic [IW-1:0] MINV = {1'b1, {(IW-1){1'b0}}};
  localparam logic [DW-1:0] DIV_END = DW'(BIT_DIV - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  function automatic logic [IW-1:0] sat_abs(input logic [IW-1:0] x);
    return x[IW-1] ? (x == MINV ? MAXV : (~x + 1'b1)) : x;
  endfunction

  logic                w_acc;
  logic [IW-1:0]       w_ai, w_aq;
  logic [AW-1:0]       w_total;
  logic                r_s1_v, r_s1_si, r_s1_sq;
  logic [IW-1:0]       r_s1_ai, r_s1_aq, r_s1_thr;
  logic [AW-1:0]       r_acc;
  logic [AVG_LOG2-1:0] r_cnt;
  logic [IW-1:0]       r_thr;
  logic                r_thr_valid;
  logic [3:0]          r_sym;
  logic                r_sym_valid;
  state_t              r_state, w_next;
  logic [3:0]          r_sh;
  logic [1:0]          r_bcnt;
  logic [DW-1:0]       r_div;
  logic                r_ovr;
  logic                w_last, w_load, w_ovr;

  assign w_acc   = bitsync & din_valid;
  assign w_ai    = sat_abs(di);
  assign w_aq    = sat_abs(dq);
  assign w_total = r_acc + AW'(w_ai) + AW'(w_aq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v      <= 1'b0;
      r_s1_si     <= 1'b0;
      r_s1_sq     <= 1'b0;
      r_s1_ai     <= '0;
      r_s1_aq     <= '0;
      r_s1_thr    <= IW'(THR_INIT);
      r_acc       <= '0;
      r_cnt       <= '0;
      r_thr       <= IW'(THR_INIT);
      r_thr_valid <= 1'b0;
      r_sym       <= '0;
      r_sym_valid <= 1'b0;
    end else begin
      r_s1_v      <= w_acc;
      r_sym_valid <= r_s1_v;
      if (w_acc) begin
        r_s1_si  <= di[IW-1];
        r_s1_sq  <= dq[IW-1];
        r_s1_ai  <= w_ai;
        r_s1_aq  <= w_aq;
        r_s1_thr <= r_thr;
        // the block's last symbol is folded into the estimate before averaging
        if (r_cnt == '1) begin
          r_thr       <= w_total[AW-1 -: IW];
          r_acc       <= '0;
          r_cnt       <= '0;
          r_thr_valid <= 1'b1;
        end else begin
          r_acc <= w_total;
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (r_s1_v)
        r_sym <= {r_s1_si, r_s1_ai > r_s1_thr, r_s1_sq, r_s1_aq > r_s1_thr};
    end
  end

  always_comb begin
    w_last = (r_state == SHIFT) && (r_bcnt == 2'd3) && (r_div == DIV_END);
    w_load = r_sym_valid && ((r_state == IDLE) || w_last);
    w_ovr  = r_sym_valid && (r_state == SHIFT) && !w_last;
    w_next = r_state;
    if (w_load) w_next = SHIFT;
    else if (w_last) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_bcnt  <= '0;
      r_div   <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_sh   <= r_sym;
        r_bcnt <= '0;
        r_div  <= '0;
      end else if (r_state == SHIFT) begin
        if (r_div == DIV_END) begin
          r_div  <= '0;
          r_bcnt <= r_bcnt + 1'b1;
          r_sh   <= {r_sh[2:0], 1'b0};
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
      if (w_ovr) r_ovr <= 1'b1;
    end
  end

  assign sym_out   = r_sym;
  assign sym_valid = r_sym_valid;
  assign bit_valid = r_state == SHIFT;
  assign bit_out   = bit_valid & r_sh[3];
  assign thr       = r_thr;
  assign thr_valid = r_thr_valid;
  assign overrun   = r_ovr;
endmodule
